// File: rtl/encoder_4to2_seq_if.sv
// Request/offer bundle of the registered priority encoder.
// The master side drives requests and acknowledges; the slave side is the encoder.
interface encoder_4to2_seq_if #(
    parameter int W = 2,
    parameter int N = 2**W
);
    logic         en;
    logic [N-1:0] i;
    logic [W-1:0] y;
    logic         valid;
    logic         ack;
    logic [N-1:0] pend;
    logic         ovf;

    modport master (
        output en, i, ack,
        input  y, valid, pend, ovf
    );

    modport slave (
        input  en, i, ack,
        output y, valid, pend, ovf
    );
endinterface

// File: rtl/encoder_4to2_seq.sv
// Registered priority encoder: latches request pulses and offers them one at a time,
// highest index first, on a valid/ack handshake.
module encoder_4to2_seq #(
    parameter int W = 2,
    parameter int N = 2**W
) (
    input  logic                clk,
    input  logic                rst_n,
    encoder_4to2_seq_if.slave   bus
);

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [N-1:0] r_pend;
    logic [W-1:0] r_y;
    logic         r_ovf;

    logic         w_load;
    logic [W-1:0] w_prio;
    logic [N-1:0] w_take;
    logic [N-1:0] w_req;
    logic [N-1:0] w_pend_next;
    logic         w_ovf_next;

    function automatic logic [W-1:0] f_prio(input logic [N-1:0] p);
        logic [W-1:0] idx;
        idx = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (p[k]) idx = k[W-1:0];
        end
        return idx;
    endfunction

    function automatic logic [N-1:0] f_onehot(input logic [W-1:0] idx);
        logic [N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Gating by en with a select keeps unknowns on i out of pend and ovf.
    assign w_req  = bus.en ? bus.i : '0;
    assign w_prio = f_prio(r_pend);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pend) begin
                    w_load       = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.ack) begin
                    if (|r_pend) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Set wins over clear: a bit re-requested while being taken stays pending.
    assign w_take      = w_load ? f_onehot(w_prio) : '0;
    assign w_pend_next = (r_pend & ~w_take) | w_req;
    assign w_ovf_next  = |(w_req & r_pend & ~w_take);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_y     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_pend_next;
            r_ovf   <= w_ovf_next;
            if (w_load) r_y <= w_prio;
        end
    end

    assign bus.y     = r_y;
    assign bus.valid = (r_state == S_HOLD);
    assign bus.pend  = r_pend;
    assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_encoder_4to2_seq.sv
// Self-checking bench for encoder_4to2_seq: scenario tasks plus a scoreboard of
// expected indices popped whenever the DUT completes a valid/ack handshake.
module tb_encoder_4to2_seq;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    logic [1:0] exp_q[$];

    encoder_4to2_seq_if #(.W(2), .N(4)) bus ();

    encoder_4to2_seq #(.W(2), .N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake completes at the next rising edge; sample on the falling edge.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.valid === 1'b1 && bus.ack === 1'b1) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scoreboard_extra: got y=%b, expected no handshake", bus.y);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.y !== e)
                        $display("FAIL scoreboard_y: got y=%b, expected %b", bus.y, e);
                    else
                        n_pass++;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; bus.en = 1'b1; bus.i = 4'b1111; bus.ack = 1'b0;
        tick(); tick();
        n_total++; if (bus.pend !== 4'b0000) $display("FAIL reset_pend: got %b, expected 0000", bus.pend); else n_pass++;
        n_total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", bus.valid); else n_pass++;
        n_total++; if (bus.y !== 2'b00) $display("FAIL reset_y: got %b, expected 00", bus.y); else n_pass++;
        n_total++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b, expected 0", bus.ovf); else n_pass++;
        bus.i = 4'b0000; rst_n = 1'b1;
        tick();
        n_total++; if (bus.valid !== 1'b0) $display("FAIL reset_release_valid: got %b, expected 0", bus.valid); else n_pass++;
    endtask

    task automatic test_single();
        bus.en = 1'b1; bus.i = 4'b0100; bus.ack = 1'b1;
        exp_q.push_back(2'b10);
        tick();
        bus.i = 4'b0000;
        n_total++; if (bus.pend !== 4'b0100) $display("FAIL single_pend: got %b, expected 0100", bus.pend); else n_pass++;
        n_total++; if (bus.valid !== 1'b0) $display("FAIL single_valid_early: got %b, expected 0", bus.valid); else n_pass++;
        tick();
        n_total++; if (bus.valid !== 1'b1 || bus.y !== 2'b10) $display("FAIL single_offer: got valid=%b y=%b, expected 1 10", bus.valid, bus.y); else n_pass++;
        tick();
        n_total++; if (bus.valid !== 1'b0 || bus.pend !== 4'b0000) $display("FAIL single_done: got valid=%b pend=%b, expected 0 0000", bus.valid, bus.pend); else n_pass++;
        bus.ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [3];
        seq[0] = 2'b11; seq[1] = 2'b01; seq[2] = 2'b00;
        bus.i = 4'b1011; bus.ack = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(seq[k]);
        tick();
        bus.i = 4'b0000;
        n_total++; if (bus.pend !== 4'b1011) $display("FAIL drain_pend: got %b, expected 1011", bus.pend); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (bus.valid !== 1'b1 || bus.y !== seq[k])
                $display("FAIL drain_step%0d: got valid=%b y=%b, expected 1 %b", k, bus.valid, bus.y, seq[k]);
            else n_pass++;
        end
        tick();
        n_total++; if (bus.valid !== 1'b0) $display("FAIL drain_end_valid: got %b, expected 0", bus.valid); else n_pass++;
        bus.ack = 1'b0;
    endtask

    task automatic test_stall_ovf();
        bus.i = 4'b0001; bus.ack = 1'b0;
        exp_q.push_back(2'b00); exp_q.push_back(2'b01); exp_q.push_back(2'b00);
        tick();
        bus.i = 4'b0000;
        tick();
        n_total++; if (bus.valid !== 1'b1 || bus.y !== 2'b00) $display("FAIL stall_offer: got valid=%b y=%b, expected 1 00", bus.valid, bus.y); else n_pass++;
        bus.i = 4'b0011;
        tick();
        n_total++; if (bus.ovf !== 1'b0 || bus.pend !== 4'b0011) $display("FAIL stall_noovf: got ovf=%b pend=%b, expected 0 0011", bus.ovf, bus.pend); else n_pass++;
        bus.i = 4'b0010;
        tick();
        n_total++; if (bus.ovf !== 1'b1 || bus.pend !== 4'b0011) $display("FAIL stall_ovf: got ovf=%b pend=%b, expected 1 0011", bus.ovf, bus.pend); else n_pass++;
        bus.i = 4'b0000;
        tick();
        n_total++; if (bus.ovf !== 1'b0) $display("FAIL stall_ovf_pulse: got %b, expected 0", bus.ovf); else n_pass++;
        n_total++; if (bus.y !== 2'b00 || bus.valid !== 1'b1) $display("FAIL stall_hold: got valid=%b y=%b, expected 1 00", bus.valid, bus.y); else n_pass++;
        bus.ack = 1'b1;
        tick();
        n_total++; if (bus.y !== 2'b01) $display("FAIL stall_next: got y=%b, expected 01", bus.y); else n_pass++;
        tick();
        n_total++; if (bus.y !== 2'b00) $display("FAIL stall_last: got y=%b, expected 00", bus.y); else n_pass++;
        tick();
        n_total++; if (bus.valid !== 1'b0) $display("FAIL stall_end_valid: got %b, expected 0", bus.valid); else n_pass++;
        bus.ack = 1'b0;
    endtask

    task automatic test_set_wins();
        bus.i = 4'b0001; bus.ack = 1'b0;
        exp_q.push_back(2'b00); exp_q.push_back(2'b00);
        tick();
        tick();
        bus.i = 4'b0000;
        n_total++;
        if (bus.pend !== 4'b0001 || bus.ovf !== 1'b0 || bus.valid !== 1'b1)
            $display("FAIL setwins: got pend=%b ovf=%b valid=%b, expected 0001 0 1", bus.pend, bus.ovf, bus.valid);
        else n_pass++;
        bus.ack = 1'b1;
        tick();
        n_total++; if (bus.valid !== 1'b1 || bus.y !== 2'b00 || bus.pend !== 4'b0000) $display("FAIL setwins_reoffer: got valid=%b y=%b pend=%b, expected 1 00 0000", bus.valid, bus.y, bus.pend); else n_pass++;
        tick();
        n_total++; if (bus.valid !== 1'b0) $display("FAIL setwins_end: got %b, expected 0", bus.valid); else n_pass++;
        bus.ack = 1'b0;
    endtask

    task automatic test_enable();
        bus.en = 1'b0; bus.i = 4'bxxxx; bus.ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (bus.pend !== 4'b0000 || bus.ovf !== 1'b0 || bus.valid !== 1'b0 ||
                $isunknown({bus.y, bus.pend, bus.ovf, bus.valid}))
                $display("FAIL enable_gate%0d: got pend=%b ovf=%b valid=%b y=%b, expected 0000 0 0 known", k, bus.pend, bus.ovf, bus.valid, bus.y);
            else n_pass++;
        end
        bus.en = 1'b1; bus.i = 4'b1000;
        exp_q.push_back(2'b11);
        tick();
        bus.i = 4'b0000;
        tick();
        n_total++; if (bus.valid !== 1'b1 || bus.y !== 2'b11) $display("FAIL enable_resume: got valid=%b y=%b, expected 1 11", bus.valid, bus.y); else n_pass++;
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.en = 1'b1; bus.i = 4'b0001; bus.ack = 1'b0;
        tick();
        bus.i = 4'b0110;
        tick();
        bus.i = 4'b0000;
        n_total++; if (bus.valid !== 1'b1 || bus.pend !== 4'b0110) $display("FAIL rstmid_setup: got valid=%b pend=%b, expected 1 0110", bus.valid, bus.pend); else n_pass++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_total++; if (bus.valid !== 1'b0 || bus.pend !== 4'b0000 || bus.y !== 2'b00) $display("FAIL rstmid_clear: got valid=%b pend=%b y=%b, expected 0 0000 00", bus.valid, bus.pend, bus.y); else n_pass++;
        bus.ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if (bus.valid !== 1'b0) $display("FAIL rstmid_quiet%0d: got valid=%b, expected 0", k, bus.valid); else n_pass++;
        end
        bus.ack = 1'b0;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst_n = 1'b0; bus.en = 1'b0; bus.i = '0; bus.ack = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall_ovf();
        test_set_wins();
        test_enable();
        test_reset_mid();
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
